cam_sleep_seq: RTL and testbench
================================

CAM_SLEEP_SEQ -- requirements
Module: cam_sleep_seq

Interface
REQ-001 The block SHALL have parameter T_QUIESCE, default 20'h00400, meaning the cycles from initial_en low to cam_rst_n low.
REQ-002 The block SHALL have parameter T_RST_HOLD, default 20'h00800, meaning the cycles from cam_rst_n low to cam_pwdn high.
REQ-003 The block SHALL have parameter T_PWDN_LOW, default 20'h04000, meaning the cycles from cam_pwdn low to cam_rst_n high on wake.
REQ-004 The block SHALL have parameter T_INIT_DLY, default 20'hfffff, meaning the cycles from cam_rst_n high to initial_en high on wake.
REQ-005 The block SHALL have parameter T_BUSY_TO, default 20'h10000, meaning the maximum cycles to wait for sccb_busy low before forcing shutdown.
REQ-006 The block SHALL have port clk  input  1  system clock (24 MHz).
REQ-007 The block SHALL have port reset  input  1  reset; one clock, synchronous, active-high.
REQ-008 The block SHALL have port sleep_req  input  1  level request: 1 = sensor asleep, 0 = sensor awake.
REQ-009 The block SHALL have port sccb_busy  input  1  SCCB master transaction in progress.
REQ-010 The block SHALL have port cam_pwdn  output  1  sensor power-down, 1 = powered down.
REQ-011 The block SHALL have port cam_rst_n  output  1  sensor reset, 0 = reset.
REQ-012 The block SHALL have port initial_en  output  1  SCCB init/traffic permitted.
REQ-013 The block SHALL have port asleep  output  1  1 only in state SLEEP.
REQ-014 The block SHALL have port busy_timeout  output  1  one-cycle pulse when the T_BUSY_TO wait expires.

Function
REQ-015 The block SHALL implement the states ACTIVE, DRAIN, QUIESCE, RST_HOLD, SLEEP, PWDN_LOW and INIT_DLY.
REQ-016 The block SHALL use one 20-bit counter that clears to 0 on every state entry and increments each cycle in timed states; a timed state SHALL exit on the cycle where counter == its parameter, so it lasts parameter+1 cycles.
REQ-017 In ACTIVE, sleep_req=1 SHALL move the block to DRAIN.
REQ-018 In DRAIN, sccb_busy=0 SHALL move the block to QUIESCE.
REQ-019 In DRAIN, if counter == T_BUSY_TO while sccb_busy=1, the block SHALL pulse busy_timeout for 1 cycle and move to QUIESCE.
REQ-020 QUIESCE SHALL move to RST_HOLD on timer expiry.
REQ-021 RST_HOLD SHALL move to SLEEP on timer expiry.
REQ-022 In SLEEP, sleep_req=0 SHALL move the block to PWDN_LOW.
REQ-023 PWDN_LOW SHALL move to INIT_DLY on timer expiry.
REQ-024 INIT_DLY SHALL move to ACTIVE on timer expiry.
REQ-025 Outputs SHALL be registered and decoded from the state: initial_en=1 only in ACTIVE; cam_rst_n=1 in ACTIVE, DRAIN, QUIESCE and INIT_DLY; cam_pwdn=1 only in SLEEP; asleep=1 only in SLEEP.
REQ-026 Outputs SHALL change on the first clock of the new state, with one cycle of latency from the transition decision.
REQ-027 initial_en SHALL fall on DRAIN entry, the same cycle sleep_req is sampled high.
REQ-028 sleep_req=0 during DRAIN, QUIESCE or RST_HOLD SHALL NOT abort the sequence; the block SHALL complete to SLEEP, then wake via PWDN_LOW.
REQ-029 sleep_req=1 during PWDN_LOW or INIT_DLY SHALL NOT abort the wake; the block SHALL reach ACTIVE for 1 cycle, then enter DRAIN.
REQ-030 cam_pwdn and cam_rst_n SHALL never be 1 and 1 simultaneously.
REQ-031 cam_rst_n SHALL never rise while cam_pwdn=1.
REQ-032 The counter SHALL saturate rather than wrap; it is only compared against parameters.
REQ-033 A parameter value of 0 SHALL give a 1-cycle state.

Reset
REQ-034 While reset=1, the state SHALL be SLEEP, the counter SHALL be 0, and outputs SHALL be cam_pwdn=1, cam_rst_n=0, initial_en=0, asleep=1, busy_timeout=0.
REQ-035 reset=1 in any state, including mid-sequence, SHALL force SLEEP on the next clock; the sensor is treated as unpowered.
REQ-036 After reset release with sleep_req=0, the block SHALL run the full wake sequence (PWDN_LOW, INIT_DLY, ACTIVE).
REQ-037 No output SHALL glitch during or after reset.

Verification
All parameters are overridden to 4 unless noted otherwise.
REQ-038 Power-up scenario: hold reset=1 for 3 cycles, then release with sleep_req=0 -> asleep=1 during reset; cam_pwdn falls 1 cycle after release; cam_rst_n rises 5 cycles later; initial_en rises 5 cycles after that.
REQ-039 Clean sleep scenario: from ACTIVE, set sleep_req=1 with sccb_busy=0 -> initial_en falls next cycle; cam_rst_n falls 6 cycles later; cam_pwdn=1 and asleep=1 5 cycles after that; busy_timeout stays 0.
REQ-040 Busy drain scenario: from ACTIVE, set sleep_req=1 with sccb_busy held 1 for 3 cycles -> DRAIN lasts 4 cycles; no busy_timeout.
REQ-041 Busy timeout scenario: with T_BUSY_TO=8 and sccb_busy stuck at 1 -> busy_timeout pulses once, 9 cycles after DRAIN entry; the sequence then continues to SLEEP.
REQ-042 Mid-sequence scenarios: drop sleep_req to 0 in QUIESCE -> the block reaches SLEEP, then wakes to ACTIVE. Assert reset=1 in INIT_DLY -> the next cycle shows cam_pwdn=1, cam_rst_n=0, initial_en=0.
REQ-043 All scenarios: an assertion SHALL check that cam_pwdn and cam_rst_n are never 1 together.

Source files
------------

// File: rtl/cam_sleep_seq.sv
// cam_sleep_seq: camera sensor sleep/wake power sequencer.
//
// Walks the sensor through an orderly shutdown (drain SCCB traffic, quiesce,
// hold reset, power down) and the reverse wake sequence (release power-down,
// wait, release reset, wait, re-enable SCCB init). A single 20-bit counter
// times every state; it clears on each state entry and saturates.
//
// Ports:
//   clk_i          system clock (24 MHz)
//   reset_i        synchronous active-high reset; forces SLEEP
//   sleep_req_i    level request, 1 = sensor asleep, 0 = awake
//   sccb_busy_i    SCCB master transaction in progress
//   cam_pwdn_o     sensor power-down, 1 = powered down
//   cam_rst_n_o    sensor reset, 0 = held in reset
//   initial_en_o   SCCB init/traffic permitted
//   asleep_o       1 only in SLEEP
//   busy_timeout_o one-cycle pulse when the SCCB drain wait gives up
module cam_sleep_seq #(
  parameter logic [19:0] T_QUIESCE  = 20'h00400,
  parameter logic [19:0] T_RST_HOLD = 20'h00800,
  parameter logic [19:0] T_PWDN_LOW = 20'h04000,
  parameter logic [19:0] T_INIT_DLY = 20'hfffff,
  parameter logic [19:0] T_BUSY_TO  = 20'h10000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic sleep_req_i,
  input  logic sccb_busy_i,
  output logic cam_pwdn_o,
  output logic cam_rst_n_o,
  output logic initial_en_o,
  output logic asleep_o,
  output logic busy_timeout_o
);

  typedef enum logic [2:0] {
    S_ACTIVE,
    S_DRAIN,
    S_QUIESCE,
    S_RST_HOLD,
    S_SLEEP,
    S_PWDN_LOW,
    S_INIT_DLY
  } state_e;

  state_e      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic        bto_d;

  // Next-state decision. Sleep requests are not looked at outside ACTIVE and
  // SLEEP, so a started sequence always runs to completion.
  always_comb begin
    state_d = state_q;
    bto_d   = 1'b0;
    case (state_q)
      S_ACTIVE:   if (sleep_req_i) state_d = S_DRAIN;
      S_DRAIN: begin
        if (!sccb_busy_i) begin
          state_d = S_QUIESCE;
        end else if (cnt_q == T_BUSY_TO) begin
          state_d = S_QUIESCE;
          bto_d   = 1'b1;
        end
      end
      S_QUIESCE:  if (cnt_q == T_QUIESCE)  state_d = S_RST_HOLD;
      S_RST_HOLD: if (cnt_q == T_RST_HOLD) state_d = S_SLEEP;
      S_SLEEP:    if (!sleep_req_i)        state_d = S_PWDN_LOW;
      S_PWDN_LOW: if (cnt_q == T_PWDN_LOW) state_d = S_INIT_DLY;
      S_INIT_DLY: if (cnt_q == T_INIT_DLY) state_d = S_ACTIVE;
      default:    state_d = S_SLEEP;
    endcase
  end

  // Counter: zero on entry and in the untimed states, otherwise saturating.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q || state_q == S_ACTIVE || state_q == S_SLEEP)
      cnt_d = '0;
    else if (cnt_q != 20'hfffff)
      cnt_d = cnt_q + 20'd1;
  end

  // Outputs are decoded from the next state so they register on the same
  // edge as the state itself; cam_rst_n is low in every state where
  // cam_pwdn can be high, so the two never overlap.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= S_SLEEP;
      cnt_q          <= '0;
      cam_pwdn_o     <= 1'b1;
      cam_rst_n_o    <= 1'b0;
      initial_en_o   <= 1'b0;
      asleep_o       <= 1'b1;
      busy_timeout_o <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cam_pwdn_o     <= (state_d == S_SLEEP);
      cam_rst_n_o    <= (state_d == S_ACTIVE)  || (state_d == S_DRAIN) ||
                        (state_d == S_QUIESCE) || (state_d == S_INIT_DLY);
      initial_en_o   <= (state_d == S_ACTIVE);
      asleep_o       <= (state_d == S_SLEEP);
      busy_timeout_o <= bto_d;
    end
  end

endmodule

// File: tb/tb_cam_sleep_seq.sv
module tb_cam_sleep_seq;
  localparam int TQ = 4, TH = 4, TP = 4, TI = 4, TB = 8;

  logic clk = 1'b0;
  logic rst, sleep_req, busy;
  logic cam_pwdn, cam_rst_n, initial_en, asleep, busy_timeout;

  always #5 clk = ~clk;

  cam_sleep_seq #(
    .T_QUIESCE (20'(TQ)), .T_RST_HOLD(20'(TH)), .T_PWDN_LOW(20'(TP)),
    .T_INIT_DLY(20'(TI)), .T_BUSY_TO (20'(TB))
  ) dut (
    .clk_i(clk), .reset_i(rst), .sleep_req_i(sleep_req), .sccb_busy_i(busy),
    .cam_pwdn_o(cam_pwdn), .cam_rst_n_o(cam_rst_n), .initial_en_o(initial_en),
    .asleep_o(asleep), .busy_timeout_o(busy_timeout)
  );

  // Behavioural model: a phase plus the cycles still to spend in it.
  localparam int M_OFF = 10, M_WAKE_PWR = 11, M_WAKE_RST = 12, M_ON = 13,
                 M_DRAIN = 14, M_QUIET = 15, M_HOLD = 16;
  int   m_ph, m_left;
  logic m_bto;

  always @(posedge clk) begin
    if (rst) begin
      m_ph <= M_OFF; m_left <= 0; m_bto <= 1'b0;
    end else begin
      m_bto <= 1'b0;
      case (m_ph)
        M_ON:    if (sleep_req) begin m_ph <= M_DRAIN; m_left <= TB; end
        M_DRAIN: if (!busy) begin m_ph <= M_QUIET; m_left <= TQ; end
                 else if (m_left == 0) begin m_ph <= M_QUIET; m_left <= TQ; m_bto <= 1'b1; end
                 else m_left <= m_left - 1;
        M_QUIET: if (m_left == 0) begin m_ph <= M_HOLD; m_left <= TH; end else m_left <= m_left - 1;
        M_HOLD:  if (m_left == 0) m_ph <= M_OFF; else m_left <= m_left - 1;
        M_OFF:   if (!sleep_req) begin m_ph <= M_WAKE_PWR; m_left <= TP; end
        M_WAKE_PWR: if (m_left == 0) begin m_ph <= M_WAKE_RST; m_left <= TI; end else m_left <= m_left - 1;
        M_WAKE_RST: if (m_left == 0) m_ph <= M_ON; else m_left <= m_left - 1;
        default: m_ph <= M_OFF;
      endcase
    end
  end

  always @(negedge clk)
    assert (!(cam_pwdn === 1'b1 && cam_rst_n === 1'b1))
      else $error("FAIL pwdn_rstn_overlap pwdn=%b rst_n=%b", cam_pwdn, cam_rst_n);

  int errors = 0, checks = 0, cyc = 0, bto_cnt = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // One clock; then compare every output against the model.
  task automatic tick;
    logic [4:0] got, exp;
    @(posedge clk); #1;
    cyc++;
    got = {cam_pwdn, cam_rst_n, initial_en, asleep, busy_timeout};
    exp = {m_ph == M_OFF,
           m_ph == M_ON || m_ph == M_DRAIN || m_ph == M_QUIET || m_ph == M_WAKE_RST,
           m_ph == M_ON, m_ph == M_OFF, m_bto};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL model cyc=%0d {pwdn,rst_n,init,asleep,bto} got=%b expected=%b", cyc, got, exp);
    end
    if (busy_timeout === 1'b1) bto_cnt++;
  endtask

  function automatic logic sel(input int w);
    case (w)
      0: return cam_pwdn;
      1: return cam_rst_n;
      2: return initial_en;
      3: return asleep;
      default: return busy_timeout;
    endcase
  endfunction

  task automatic run_until(input int w, input logic val, input int maxc, output int at);
    at = -1;
    for (int i = 0; i < maxc && at < 0; i++) begin
      tick;
      if (sel(w) === val) at = cyc;
    end
    checks++;
    if (at < 0) begin
      errors++;
      $display("FAIL wait_out%0d got=timeout expected=%b within %0d cycles", w, val, maxc);
    end
  endtask

  int a, t0, t1, t2, t3;

  initial begin
    rst = 1'b1; sleep_req = 1'b0; busy = 1'b0;
    repeat (3) tick;
    chk("rst_asleep", int'(asleep), 1);
    chk("rst_pwdn", int'(cam_pwdn), 1);
    chk("rst_rstn", int'(cam_rst_n), 0);
    chk("rst_init", int'(initial_en), 0);
    chk("rst_bto", int'(busy_timeout), 0);

    // Power-up wake
    rst = 1'b0; t0 = cyc;
    run_until(0, 1'b0, 20, t1); chk("pu_pwdn_fall", t1 - t0, 1);
    run_until(1, 1'b1, 20, t2); chk("pu_rstn_rise", t2 - t1, 5);
    run_until(2, 1'b1, 20, t3); chk("pu_init_rise", t3 - t2, 5);

    // Clean sleep
    tick;
    sleep_req = 1'b1; busy = 1'b0; bto_cnt = 0; a = cyc;
    run_until(2, 1'b0, 20, t1); chk("clean_init_fall", t1 - a, 1);
    run_until(1, 1'b0, 20, t2); chk("clean_rstn_fall", t2 - t1, 6);
    run_until(3, 1'b1, 20, t3); chk("clean_asleep", t3 - t2, 5);
    chk("clean_pwdn", int'(cam_pwdn), 1);
    chk("clean_no_bto", bto_cnt, 0);

    // Busy drain: busy seen high for 3 DRAIN cycles
    sleep_req = 1'b0;
    run_until(2, 1'b1, 30, t1);
    sleep_req = 1'b1; busy = 1'b1; bto_cnt = 0; a = cyc;
    repeat (4) tick;
    busy = 1'b0;
    run_until(1, 1'b0, 30, t2); chk("drain_rstn_fall", t2 - a, 10);
    run_until(3, 1'b1, 30, t3);
    chk("drain_no_bto", bto_cnt, 0);

    // Busy timeout with sccb_busy stuck
    sleep_req = 1'b0;
    run_until(2, 1'b1, 30, t1);
    sleep_req = 1'b1; busy = 1'b1; bto_cnt = 0; a = cyc;
    run_until(4, 1'b1, 30, t1); chk("bto_delay", t1 - (a + 1), 9);
    run_until(3, 1'b1, 30, t2); chk("bto_to_sleep", t2 - t1, 10);
    chk("bto_once", bto_cnt, 1);
    busy = 1'b0;

    // Sleep request dropped in QUIESCE: still completes to SLEEP, then wakes
    sleep_req = 1'b0;
    run_until(2, 1'b1, 30, t1);
    sleep_req = 1'b1; a = cyc;
    tick; tick;
    sleep_req = 1'b0;
    run_until(3, 1'b1, 30, t1); chk("abort_sleep_reached", t1 - a, 12);
    run_until(2, 1'b1, 30, t2); chk("abort_wake", t2 - t1, 11);

    // Sleep request during wake: ACTIVE for one cycle, then DRAIN
    sleep_req = 1'b1;
    run_until(3, 1'b1, 30, t1);
    sleep_req = 1'b0;
    tick; tick;
    sleep_req = 1'b1;
    run_until(2, 1'b1, 30, t1);
    tick;
    chk("wake_active_1cyc", int'(initial_en), 0);
    chk("wake_then_drain", int'(cam_rst_n), 1);

    // Reset asserted in INIT_DLY
    sleep_req = 1'b0;
    run_until(3, 1'b1, 30, t1);
    run_until(1, 1'b1, 30, t2);
    tick;
    rst = 1'b1;
    tick;
    chk("midrst_pwdn", int'(cam_pwdn), 1);
    chk("midrst_rstn", int'(cam_rst_n), 0);
    chk("midrst_init", int'(initial_en), 0);
    chk("midrst_asleep", int'(asleep), 1);
    rst = 1'b0;
    run_until(2, 1'b1, 30, t1); chk("midrst_rewake", t1 - (cyc - 11), 11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
